// File: rtl/water_tank_model_if.sv
// Tank plant interface.
//   master : controller side; drives pump commands and the drain valve,
//            receives sensors, level and status flags.
//   slave  : tank model side; the mirror image.
// Signals:
//   b1, b2    pump enable commands
//   drain     consumer valve open
//   s1..s4    thermometer-coded level sensors
//   level     current tank level
//   overflow  sticky fill-past-capacity flag
//   dry       drain requested against an empty tank
interface water_tank_model_if #(
  parameter int LEVEL_W = 8
);
  logic               b1;
  logic               b2;
  logic               drain;
  logic               s1;
  logic               s2;
  logic               s3;
  logic               s4;
  logic [LEVEL_W-1:0] level;
  logic               overflow;
  logic               dry;

  modport master (
    output b1, b2, drain,
    input  s1, s2, s3, s4, level, overflow, dry
  );

  modport slave (
    input  b1, b2, drain,
    output s1, s2, s3, s4, level, overflow, dry
  );
endinterface

// File: rtl/water_tank_model.sv
// Water tank plant model for closed-loop runs against the pump controller.
// Integrates the tank level from two pumps (each with a spin-up delay) and a
// drain valve, with saturating arithmetic, and produces registered level
// sensors plus overflow/dry status.
// Ports:
//   clk   single clock, all state on the rising edge
//   rst   synchronous, active-high; overrides every input
//   tank  water_tank_model_if.slave (b1/b2/drain in; s1..s4, level,
//         overflow, dry out)
// Parameter constraints: MAX_LEVEL < 2**LEVEL_W, SPINUP_CYC >= 1,
// T1 < T2 < T3 < T4 <= MAX_LEVEL.

// One pump: OFF -> SPINUP -> RUN. 'run' is registered and equals
// (state == RUN), so the level update at an edge sees the pre-edge state.
module wtm_pump #(
  parameter int SPINUP_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd,
  output logic run
);
  localparam int CNT_W = (SPINUP_CYC < 1) ? 1 : $clog2(SPINUP_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPINUP_CYC - 1);

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    SPINUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      cnt   <= '0;
      run   <= 1'b0;
    end else begin
      case (state)
        OFF: begin
          if (cmd) begin
            state <= SPINUP;
            cnt   <= '0;
          end
          run <= 1'b0;
        end
        SPINUP: begin
          if (!cmd) begin
            state <= OFF;
            run   <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state <= RUN;
            run   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            run <= 1'b0;
          end
        end
        RUN: begin
          // Dropping the command takes effect on this edge; the level
          // update on the same edge still counts this pump once more.
          if (!cmd) begin
            state <= OFF;
            run   <= 1'b0;
          end else begin
            run <= 1'b1;
          end
        end
        default: begin
          state <= OFF;
          cnt   <= '0;
          run   <= 1'b0;
        end
      endcase
    end
  end
endmodule

module water_tank_model #(
  parameter int LEVEL_W    = 8,
  parameter int MAX_LEVEL  = 200,
  parameter int FILL_RATE  = 2,
  parameter int DRAIN_RATE = 3,
  parameter int SPINUP_CYC = 4,
  parameter int T1         = 20,
  parameter int T2         = 80,
  parameter int T3         = 140,
  parameter int T4         = 190
) (
  input  logic               clk,
  input  logic               rst,
  water_tank_model_if.slave  tank
);
  localparam int NUM_PUMPS = 2;
  localparam int NUM_SENS  = 4;
  // Two guard bits: one for headroom above MAX_LEVEL, one for sign.
  localparam int SW        = LEVEL_W + 2;

  localparam logic signed [SW-1:0]  MAX_S   = SW'(MAX_LEVEL);
  localparam logic signed [SW-1:0]  FILL_S  = SW'(FILL_RATE);
  localparam logic signed [SW-1:0]  DRAIN_S = SW'(DRAIN_RATE);
  localparam logic [LEVEL_W-1:0]    MAX_L   = LEVEL_W'(MAX_LEVEL);
  localparam logic [NUM_SENS-1:0][LEVEL_W-1:0] THR = {
    LEVEL_W'(T4), LEVEL_W'(T3), LEVEL_W'(T2), LEVEL_W'(T1)
  };

  // ---------------------------------------------------------------- pumps
  logic [NUM_PUMPS-1:0] pump_cmd;
  logic [NUM_PUMPS-1:0] pump_run;

  assign pump_cmd = {tank.b2, tank.b1};

  for (genvar g = 0; g < NUM_PUMPS; g++) begin : g_pump
    wtm_pump #(
      .SPINUP_CYC (SPINUP_CYC)
    ) u_pump (
      .clk (clk),
      .rst (rst),
      .cmd (pump_cmd[g]),
      .run (pump_run[g])
    );
  end

  // ---------------------------------------------------------------- level
  logic [LEVEL_W-1:0]       level_q;
  logic [NUM_SENS-1:0]      sens_q;
  logic                     overflow_q;
  logic                     dry_q;

  logic signed [SW-1:0]     inflow;
  logic signed [SW-1:0]     outflow;
  logic signed [SW-1:0]     sum;
  logic [LEVEL_W-1:0]       level_nxt;
  logic                     over;

  // Fill and drain are netted in one step; clamping only happens on the
  // final sum, so a simultaneous fill and drain never saturates midway.
  always_comb begin
    inflow = '0;
    for (int i = 0; i < NUM_PUMPS; i++) begin
      if (pump_run[i]) inflow = inflow + FILL_S;
    end
    outflow = tank.drain ? DRAIN_S : '0;
    sum     = $signed({2'b00, level_q}) + inflow - outflow;
    over    = (sum > MAX_S);

    if (sum < 0)   level_nxt = '0;
    else if (over) level_nxt = MAX_L;
    else           level_nxt = sum[LEVEL_W-1:0];
  end

  // Sensors are computed from the same next value that loads level_q, so
  // they always agree with Level and are thermometer-coded by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q    <= '0;
      sens_q     <= '0;
      overflow_q <= 1'b0;
      dry_q      <= 1'b0;
    end else begin
      level_q <= level_nxt;
      for (int k = 0; k < NUM_SENS; k++) begin
        sens_q[k] <= (level_nxt >= THR[k]);
      end
      if (over) overflow_q <= 1'b1;
      dry_q <= (level_nxt == '0) && tank.drain;
    end
  end

  assign tank.level    = level_q;
  assign tank.s1       = sens_q[0];
  assign tank.s2       = sens_q[1];
  assign tank.s3       = sens_q[2];
  assign tank.s4       = sens_q[3];
  assign tank.overflow = overflow_q;
  assign tank.dry      = dry_q;
endmodule

// File: tb/tb_water_tank_model.sv
module tb_water_tank_model;
  localparam int LEVEL_W    = 8;
  localparam int MAX_LEVEL  = 200;
  localparam int FILL_RATE  = 2;
  localparam int DRAIN_RATE = 3;
  localparam int SPINUP_CYC = 4;
  localparam int T1 = 20, T2 = 80, T3 = 140, T4 = 190;

  logic clk = 1'b0;
  logic rst = 1'b1;

  water_tank_model_if #(.LEVEL_W(LEVEL_W)) tank ();

  water_tank_model #(
    .LEVEL_W    (LEVEL_W),
    .MAX_LEVEL  (MAX_LEVEL),
    .FILL_RATE  (FILL_RATE),
    .DRAIN_RATE (DRAIN_RATE),
    .SPINUP_CYC (SPINUP_CYC),
    .T1 (T1), .T2 (T2), .T3 (T3), .T4 (T4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .tank (tank)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a pump delivers water once its command has been seen
  // high on more than SPINUP_CYC consecutive edges before the current one.
  int m_level = 0;
  bit m_ov    = 1'b0;
  bit m_dry   = 1'b0;
  int h1      = 0;
  int h2      = 0;

  function automatic int raw_next(int lvl, int ha, int hb, bit dr);
    int n;
    n = (ha > SPINUP_CYC ? 1 : 0) + (hb > SPINUP_CYC ? 1 : 0);
    return lvl + FILL_RATE * n - (dr ? DRAIN_RATE : 0);
  endfunction

  function automatic int clampv(int v);
    if (v < 0) return 0;
    if (v > MAX_LEVEL) return MAX_LEVEL;
    return v;
  endfunction

  function automatic int hold(int h, logic b);
    if (b !== 1'b1) return 0;
    return (h < 1000) ? h + 1 : h;
  endfunction

  function automatic int sens_of(int lvl);
    return ((lvl >= T4) ? 8 : 0) | ((lvl >= T3) ? 4 : 0) |
           ((lvl >= T2) ? 2 : 0) | ((lvl >= T1) ? 1 : 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_level <= 0;
      m_ov    <= 1'b0;
      m_dry   <= 1'b0;
      h1      <= 0;
      h2      <= 0;
    end else begin
      m_level <= clampv(raw_next(m_level, h1, h2, tank.drain));
      m_ov    <= m_ov || (raw_next(m_level, h1, h2, tank.drain) > MAX_LEVEL);
      m_dry   <= (clampv(raw_next(m_level, h1, h2, tank.drain)) == 0) && tank.drain;
      h1      <= hold(h1, tank.b1);
      h2      <= hold(h2, tank.b2);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_level",    tank.level, m_level);
    chk("cyc_sensors",  {tank.s4, tank.s3, tank.s2, tank.s1}, sens_of(m_level));
    chk("cyc_overflow", tank.overflow, int'(m_ov));
    chk("cyc_dry",      tank.dry, int'(m_dry));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] sens();
    return {28'd0, tank.s4, tank.s3, tank.s2, tank.s1};
  endfunction

  initial begin
    tank.b1 = 1'b1; tank.b2 = 1'b1; tank.drain = 1'b1;
    rst = 1'b1;

    // Reset dominates inputs held high.
    tick(3);
    chk("rst_level", tank.level, 0);
    chk("rst_sens", sens(), 0);
    chk("rst_ovf", tank.overflow, 0);
    chk("rst_dry", tank.dry, 0);
    rst = 1'b0;
    tick(1);
    chk("post_rst_level", tank.level, 0);

    // Single pump fill from empty; B1 first sampled at edge 1.
    rst = 1'b1; tank.b1 = 1'b0; tank.b2 = 1'b0; tank.drain = 1'b0;
    tick(1);
    rst = 1'b0; tank.b1 = 1'b1;
    tick(5);  chk("fill_e5",  tank.level, 0);
    tick(1);  chk("fill_e6",  tank.level, 2);
    tick(1);  chk("fill_e7",  tank.level, 4);
    tick(7);  chk("fill_e14", tank.level, 18);
              chk("fill_e14_s", sens(), 0);
    tick(1);  chk("fill_e15", tank.level, 20);
              chk("fill_e15_s", sens(), 1);
              chk("model_e15", m_level, 20);
    tick(30); chk("fill_e45", tank.level, 80);
              chk("fill_e45_s", sens(), 3);
    tick(45); tank.b2 = 1'b1;          // level 170, B2 spins up
    tick(5);  chk("two_180", tank.level, 180);
              chk("two_180_s", sens(), 7);
    tick(1);  chk("two_184", tank.level, 184);
    tick(1);  chk("two_188", tank.level, 188);
    tick(1);  chk("two_192", tank.level, 192);
              chk("two_192_s", sens(), 15);
    tick(1);  chk("two_196", tank.level, 196);
    tick(1);  chk("two_200", tank.level, 200);
              chk("two_200_ovf", tank.overflow, 0);
    tick(1);  chk("full_level", tank.level, 200);
              chk("full_ovf", tank.overflow, 1);
              chk("model_ovf", int'(m_ov), 1);
    tank.b1 = 1'b0; tank.b2 = 1'b0;
    tick(4);  chk("ovf_sticky", tank.overflow, 1);
              chk("off_level", tank.level, 200);

    // Drain down to empty.
    tank.drain = 1'b1;
    tick(65); chk("drain_5", tank.level, 5);
    tick(1);  chk("drain_2", tank.level, 2);
              chk("drain_2_dry", tank.dry, 0);
    tick(1);  chk("drain_0", tank.level, 0);
              chk("drain_0_dry", tank.dry, 1);
    tick(1);  chk("dry_hold", tank.dry, 1);
    tank.drain = 1'b0;
    tick(1);  chk("dry_clear", tank.dry, 0);
              chk("dry_clear_lvl", tank.level, 0);
              chk("ovf_still", tank.overflow, 1);

    rst = 1'b1;
    tick(1);  chk("rst_ovf_clear", tank.overflow, 0);
    rst = 1'b0;

    // Short pulse never reaches RUN.
    tank.b1 = 1'b1;
    tick(3);
    tank.b1 = 1'b0;
    tick(6);  chk("pulse_level", tank.level, 0);
              chk("pulse_sens", sens(), 0);

    // Reset in the middle of a fill with B1 held restarts spin-up.
    tank.b1 = 1'b1;
    tick(8);  chk("midfill", tank.level, 6);
    rst = 1'b1;
    tick(1);  chk("midfill_rst", tank.level, 0);
    rst = 1'b0;
    tick(5);  chk("restart_e5", tank.level, 0);
    tick(1);  chk("restart_e6", tank.level, 2);

    // One pump plus drain nets -1 per cycle across the T2 boundary.
    tick(41); chk("net_84", tank.level, 84);
    tank.drain = 1'b1;
    tick(3);  chk("net_81", tank.level, 81);
    tick(1);  chk("net_80", tank.level, 80);
              chk("net_80_s", sens(), 3);
    tick(1);  chk("net_79", tank.level, 79);
              chk("net_79_s", sens(), 1);

    tank.b1 = 1'b0; tank.drain = 1'b0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/water_tank_model.md
# water_tank_model

Synthesizable plant model of the water tank that closes the loop around the water-pump controller. It consumes the controller's pump commands B1/B2 and a consumer Drain valve, integrates tank level with pump spin-up delay and saturating arithmetic, and produces the four thermometer-coded level sensors S1..S4 that feed back into the controller. It is used in closed-loop simulation and on the board in place of physical sensors.

## Interface
- LEVEL_W, 8, width of the level register; MAX_LEVEL must be < 2^LEVEL_W
- MAX_LEVEL, 200, tank capacity in level units
- FILL_RATE, 2, units added per cycle per running pump
- DRAIN_RATE, 3, units removed per cycle while Drain=1
- SPINUP_CYC, 4, cycles from pump command to delivered flow; must be >= 1
- T1, T2, T3, T4, 20/80/140/190, sensor thresholds; strictly increasing, T4 <= MAX_LEVEL
- Clock  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- B1, B2  in  1 each  pump enable commands from the controller
- Drain  in  1  consumer valve open
- S1, S2, S3, S4  out  1 each  level sensors, S_k = 1 when Level >= T_k
- Level  out  LEVEL_W  current tank level
- Overflow  out  1  sticky: fill attempted at full tank
- Dry  out  1  drain requested with tank at 0

## Operation
- Per pump, an independent FSM, states OFF, SPINUP, RUN, with a spin-up counter of ceil(log2(SPINUP_CYC+1)) bits.
  - OFF: B=1 -> SPINUP, cnt <= 0; else stay.
  - SPINUP: B=0 -> OFF. Else, if cnt == SPINUP_CYC-1 -> RUN; otherwise cnt <= cnt+1.
  - RUN: B=0 -> OFF; else stay.
- inflow = FILL_RATE × (number of pumps in RUN this cycle). outflow = DRAIN_RATE when Drain=1, else 0.
- next = Level + inflow - outflow.
  - Compute in LEVEL_W+2 signed bits.
  - Clamp to 0 when negative.
  - Clamp to MAX_LEVEL when greater than MAX_LEVEL.
- Level <= next every cycle.
- S_k <= (next >= T_k). Sensors and Level update on the same edge, so S is always consistent with Level. S is thermometer-coded by construction; S4=1 implies S1..S3=1.
- Overflow <= 1 when Level + inflow - outflow > MAX_LEVEL. It holds until Reset.
- Dry <= (next == 0) && Drain. It is not sticky and re-evaluates every cycle.
- Simultaneous fill and drain: the net value is applied in a single step, with no intermediate clamp.

## Timing
- Reset: Level=0, S1..S4=0, Overflow=0, Dry=0, both FSMs OFF, counters 0. Reset has priority over all inputs, including B held high.
- Reset mid-fill or mid-spin-up: all state returns to reset values at that edge. If B is still high, spin-up restarts from 0 on the first edge after Reset deasserts.
- Pump latency: B sampled 1 at edge k gives RUN at edge k+SPINUP_CYC. The first level increase is at edge k+SPINUP_CYC+1.
- A B pulse shorter than SPINUP_CYC cycles never reaches RUN and adds no water.
- Turn-off: B sampled 0 at edge j (FSM in RUN) gives OFF at edge j. That edge's level update still uses the pre-edge RUN state, so exactly one trailing increment occurs. None follow.
- Outputs are all registered; no combinational path from any input to any output.

## Test plan
- Reset with B1=B2=Drain=1 held -> Level=0, S=0000, Overflow=0, Dry=0. Next edge after Reset drops: both FSMs in SPINUP, Level still 0.
- B1=1 from edge 1, Drain=0, defaults -> RUN at edge 5; Level=2 at edge 6, 4 at edge 7; Level=20 and S1=1 at edge 15; S2 at Level 80 (edge 45).
- B1=B2=1 from Level 180 in RUN -> 184, 188, 192 (S4=1), 196, 200; next edge Level stays 200 and Overflow=1. Overflow stays 1 after B1=B2=0, until Reset.
- Level 5, pumps OFF, Drain=1 -> Level 2, then 0 with Dry=1. Dry stays 1 while Drain=1. Drain=0 -> Dry=0 on the next edge, Level 0.
- B1 high for 3 cycles, then low -> FSM returns OFF, Level unchanged, S unchanged.
- One pump running plus Drain=1 at Level 81 -> Level 80, S2 stays 1. Next edge Level 79 and S2=0; S1 remains 1.
